// File: rtl/rom_loader_if.sv
// Download bus between the HPS byte stream and the loader, plus the
// loader's write port toward the core ROMs.
interface rom_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [1:0]  rom_sel;

    // Download source: drives the ioctl stream, observes ROM writes.
    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr, rom_sel
    );

    // Loader: consumes the ioctl stream, drives the ROM write port.
    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr, rom_sel
    );
endinterface

// File: rtl/rom_loader.sv
// ROM loader: splits a sequential HPS download into program and vector
// ROM writes, validates the stream, sums accepted bytes and holds the
// game core in reset until a complete, well-formed image has landed.
module rom_loader #(
    parameter int unsigned PROG_BYTES  = 8192,
    parameter int unsigned VROM_BYTES  = 4096,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic              clk_25,
    input  logic              reset,
    rom_loader_if.slave       bus,
    output logic              load_done,
    output logic              load_err,
    output logic [15:0]       checksum,
    output logic              core_reset
);

    localparam logic [24:0] PROG_LIMIT  = 25'(PROG_BYTES);
    localparam logic [24:0] TOTAL_BYTES = 25'(PROG_BYTES + VROM_BYTES);
    localparam int          HOLD_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_HOLD = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } state_t;

    // One-hot ROM select for an absolute stream address.
    function automatic logic [1:0] region_sel(input logic [24:0] addr);
        logic [1:0] sel;
        if (addr < PROG_LIMIT) begin
            sel = 2'b01;
        end else begin
            sel = 2'b10;
        end
        return sel;
    endfunction

    // Region-relative byte address; the vector ROM starts at zero.
    function automatic logic [15:0] region_offset(input logic [24:0] addr);
        logic [24:0] rel;
        if (addr < PROG_LIMIT) begin
            rel = addr;
        end else begin
            rel = addr - PROG_LIMIT;
        end
        return rel[15:0];
    endfunction

    state_t            state_q,     state_d;
    logic              dl_prev_q,   dl_prev_d;
    logic [24:0]       count_q,     count_d;
    logic              err_flag_q,  err_flag_d;
    logic [HOLD_W-1:0] hold_cnt_q,  hold_cnt_d;
    logic [15:0]       checksum_q,  checksum_d;
    logic              load_done_q, load_done_d;
    logic              load_err_q,  load_err_d;
    logic              core_rst_q,  core_rst_d;
    logic              dn_wr_q,     dn_wr_d;
    logic [15:0]       dn_addr_q,   dn_addr_d;
    logic [7:0]        dn_data_q,   dn_data_d;
    logic [1:0]        rom_sel_q,   rom_sel_d;

    logic              rise_s;
    logic              fall_s;
    logic              byte_ok_s;

    // Download edge detection and in-order / in-range test of the current strobe.
    always_comb begin
        rise_s    = bus.ioctl_download & ~dl_prev_q;
        fall_s    = ~bus.ioctl_download & dl_prev_q;
        byte_ok_s = (bus.ioctl_addr == count_q) && (bus.ioctl_addr < TOTAL_BYTES);
    end

    // Next-state and next-output computation for the whole loader.
    always_comb begin
        state_d     = state_q;
        dl_prev_d   = bus.ioctl_download;
        count_d     = count_q;
        err_flag_d  = err_flag_q;
        hold_cnt_d  = hold_cnt_q;
        checksum_d  = checksum_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        dn_wr_d     = 1'b0;
        dn_addr_d   = dn_addr_q;
        dn_data_d   = dn_data_q;
        rom_sel_d   = 2'b00;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (rise_s) begin
                    state_d     = ST_LOAD;
                    count_d     = 25'd0;
                    err_flag_d  = 1'b0;
                    checksum_d  = 16'd0;
                    load_done_d = 1'b0;
                    load_err_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end

            ST_LOAD: begin
                // The strobe is judged first so a byte landing on the
                // falling edge still counts toward completeness.
                if (bus.ioctl_wr) begin
                    if (byte_ok_s) begin
                        count_d    = count_q + 25'd1;
                        checksum_d = checksum_q + {8'd0, bus.ioctl_dout};
                        dn_wr_d    = 1'b1;
                        dn_addr_d  = region_offset(bus.ioctl_addr);
                        dn_data_d  = bus.ioctl_dout;
                        rom_sel_d  = region_sel(bus.ioctl_addr);
                    end else begin
                        err_flag_d = 1'b1;
                    end
                end else begin
                    err_flag_d = err_flag_q;
                end

                if (fall_s) begin
                    if ((count_d == TOTAL_BYTES) && !err_flag_d) begin
                        state_d    = ST_HOLD;
                        hold_cnt_d = '0;
                    end else begin
                        state_d    = ST_ERR;
                        load_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end

            ST_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d     = ST_DONE;
                    load_done_d = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + {{(HOLD_W-1){1'b0}}, 1'b1};
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The core only runs once the loader has settled in DONE.
        core_rst_d = (state_d != ST_DONE);
    end

    // State and output registers; the download history resets high so a
    // download still active across reset is never taken as a fresh start.
    always_ff @(posedge clk_25 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dl_prev_q   <= 1'b1;
            count_q     <= 25'd0;
            err_flag_q  <= 1'b0;
            hold_cnt_q  <= '0;
            checksum_q  <= 16'd0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
            core_rst_q  <= 1'b1;
            dn_wr_q     <= 1'b0;
            dn_addr_q   <= 16'd0;
            dn_data_q   <= 8'd0;
            rom_sel_q   <= 2'b00;
        end else begin
            state_q     <= state_d;
            dl_prev_q   <= dl_prev_d;
            count_q     <= count_d;
            err_flag_q  <= err_flag_d;
            hold_cnt_q  <= hold_cnt_d;
            checksum_q  <= checksum_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
            core_rst_q  <= core_rst_d;
            dn_wr_q     <= dn_wr_d;
            dn_addr_q   <= dn_addr_d;
            dn_data_q   <= dn_data_d;
            rom_sel_q   <= rom_sel_d;
        end
    end

    assign bus.dn_wr   = dn_wr_q;
    assign bus.dn_addr = dn_addr_q;
    assign bus.dn_data = dn_data_q;
    assign bus.rom_sel = rom_sel_q;
    assign load_done   = load_done_q;
    assign load_err    = load_err_q;
    assign checksum    = checksum_q;
    assign core_reset  = core_rst_q;

endmodule

// File: tb/tb_rom_loader.sv
// Bench for rom_loader: directed table, full-image loads, error and
// reset corner cases, and randomized downloads against a reference model.
module tb_rom_loader;
    localparam int PROG  = 8192;
    localparam int VROM  = 4096;
    localparam int HOLD  = 16;
    localparam int TOTAL = PROG + VROM;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_HOLD = 2;
    localparam int PH_DONE = 3;
    localparam int PH_ERR  = 4;

    logic        clk_25 = 1'b0;
    logic        reset;
    logic        load_done;
    logic        load_err;
    logic [15:0] checksum;
    logic        core_reset;

    rom_loader_if bus ();

    rom_loader #(.PROG_BYTES(PROG), .VROM_BYTES(VROM), .HOLD_CYCLES(HOLD)) dut (
        .clk_25     (clk_25),
        .reset      (reset),
        .bus        (bus),
        .load_done  (load_done),
        .load_err   (load_err),
        .checksum   (checksum),
        .core_reset (core_reset)
    );

    always #5 clk_25 = ~clk_25;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: download phase, bytes accepted, running sum
    int          m_phase = PH_IDLE;
    int          m_count = 0;
    int          m_hold  = 0;
    bit          m_err   = 1'b0;
    bit          m_prev  = 1'b1;
    int unsigned m_chk   = 0;
    int          stream_bad = 0;
    int          pulses = 0;

    typedef struct {
        int         addr;
        logic [7:0] data;
        bit         exp_wr;
        logic [1:0] exp_sel;
        logic [15:0] exp_addr;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_count = 0;
        m_chk   = 0;
        m_err   = 1'b0;
        m_hold  = 0;
        m_prev  = 1'b1;
    endtask

    // Drive one cycle of stimulus, advance the model, compare after the edge.
    task automatic step(input bit dl, input bit wr, input int addr, input logic [7:0] data);
        bit rise;
        bit fall;
        bit exp_wr;
        int exp_sel;
        int exp_addr;
        bus.ioctl_download = dl;
        bus.ioctl_wr       = wr;
        bus.ioctl_addr     = 25'(addr);
        bus.ioctl_dout     = data;
        rise = dl && !m_prev;
        fall = !dl && m_prev;
        exp_wr = 1'b0;
        exp_sel = 0;
        exp_addr = 0;
        if (m_phase == PH_LOAD) begin
            if (wr) begin
                if (addr == m_count && addr < TOTAL) begin
                    exp_wr   = 1'b1;
                    exp_sel  = (addr < PROG) ? 1 : 2;
                    exp_addr = ((addr < PROG) ? addr : addr - PROG) % 65536;
                    m_count++;
                    m_chk = (m_chk + data) % 65536;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (fall) begin
                if (m_count == TOTAL && !m_err) begin
                    m_phase = PH_HOLD;
                    m_hold  = HOLD;
                end else begin
                    m_phase = PH_ERR;
                end
            end
        end else if (m_phase == PH_HOLD) begin
            m_hold--;
            if (m_hold == 0) m_phase = PH_DONE;
        end else if (rise) begin
            m_phase = PH_LOAD;
            m_count = 0;
            m_chk   = 0;
            m_err   = 1'b0;
        end
        m_prev = dl;
        @(posedge clk_25);
        #1;
        if (bus.dn_wr === 1'b1) pulses++;
        if (bus.dn_wr !== exp_wr || bus.rom_sel !== 2'(exp_sel)) stream_bad++;
        else if (exp_wr && (bus.dn_addr !== 16'(exp_addr) || bus.dn_data !== data)) stream_bad++;
        if (core_reset !== (m_phase != PH_DONE) || load_done !== (m_phase == PH_DONE) ||
            load_err !== (m_phase == PH_ERR) || checksum !== 16'(m_chk)) stream_bad++;
        bus.ioctl_wr = 1'b0;
    endtask

    // Complete image; optional addr pattern data, 0xA5 probe at 8192, last byte on the falling edge.
    task automatic full_load(input bit pattern, input bit last_on_fall, input string tag);
        logic [7:0] d;
        for (int a = 0; a < TOTAL; a++) begin
            if ($urandom_range(0, 3) == 0) step(1'b1, 1'b0, 0, 8'h00);
            d = pattern ? 8'(a) : 8'($urandom_range(0, 255));
            if (!pattern && a == PROG) d = 8'hA5;
            if (a == TOTAL - 1 && last_on_fall) step(1'b0, 1'b1, a, d);
            else step(1'b1, 1'b1, a, d);
            if (!pattern && a == PROG) begin
                check({tag, "_vec0_wr"},   32'(bus.dn_wr),   32'd1);
                check({tag, "_vec0_sel"},  32'(bus.rom_sel), 32'd2);
                check({tag, "_vec0_addr"}, 32'(bus.dn_addr), 32'd0);
                check({tag, "_vec0_data"}, 32'(bus.dn_data), 32'hA5);
            end
        end
        if (!last_on_fall) step(1'b0, 1'b0, 0, 8'h00);
    endtask

    task automatic measure_hold(input string tag);
        int n;
        n = 0;
        while (core_reset === 1'b1 && n < 100) begin
            step(1'b0, 1'b0, 0, 8'h00);
            n++;
        end
        check({tag, "_hold_cycles"}, 32'(n), 32'(HOLD));
        check({tag, "_load_done"},   32'(load_done), 32'd1);
        check({tag, "_load_err"},    32'(load_err),  32'd0);
    endtask

    initial begin
        tbl[0] = '{0,          8'h11, 1'b1, 2'b01, 16'd0};
        tbl[1] = '{1,          8'h22, 1'b1, 2'b01, 16'd1};
        tbl[2] = '{1,          8'h33, 1'b0, 2'b00, 16'd0};
        tbl[3] = '{3,          8'h44, 1'b0, 2'b00, 16'd0};
        tbl[4] = '{2,          8'h55, 1'b1, 2'b01, 16'd2};
        tbl[5] = '{32'h1FFFFFF, 8'hAA, 1'b0, 2'b00, 16'd0};

        bus.ioctl_download = 1'b0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = 25'd0;
        bus.ioctl_dout     = 8'd0;
        reset = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_25);
        #1;
        check("rst_dn_wr",      32'(bus.dn_wr),   32'd0);
        check("rst_dn_addr",    32'(bus.dn_addr), 32'd0);
        check("rst_dn_data",    32'(bus.dn_data), 32'd0);
        check("rst_rom_sel",    32'(bus.rom_sel), 32'd0);
        check("rst_load_done",  32'(load_done),   32'd0);
        check("rst_load_err",   32'(load_err),    32'd0);
        check("rst_checksum",   32'(checksum),    32'd0);
        check("rst_core_reset", 32'(core_reset),  32'd1);
        reset = 1'b0;

        // directed table: order/range errors mixed with accepted bytes
        stream_bad = 0;
        step(1'b0, 1'b1, 0, 8'h99);
        check("idle_wr_ignored", 32'(bus.dn_wr), 32'd0);
        step(1'b1, 1'b0, 0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, tbl[i].addr, tbl[i].data);
            check($sformatf("tbl%0d_wr", i),  32'(bus.dn_wr),   32'(tbl[i].exp_wr));
            check($sformatf("tbl%0d_sel", i), 32'(bus.rom_sel), 32'(tbl[i].exp_sel));
            if (tbl[i].exp_wr) begin
                check($sformatf("tbl%0d_addr", i), 32'(bus.dn_addr), 32'(tbl[i].exp_addr));
                check($sformatf("tbl%0d_data", i), 32'(bus.dn_data), 32'(tbl[i].data));
            end
        end
        check("tbl_checksum", 32'(checksum), 32'h88);
        step(1'b0, 1'b0, 0, 8'h00);
        check("tbl_load_err",   32'(load_err),   32'd1);
        check("tbl_load_done",  32'(load_done),  32'd0);
        check("tbl_core_reset", 32'(core_reset), 32'd1);
        check("tbl_stream",     32'(stream_bad), 32'd0);

        // full image, byte = addr[7:0], separate falling edge
        stream_bad = 0;
        pulses = 0;
        step(1'b1, 1'b0, 0, 8'h00);
        full_load(1'b1, 1'b0, "img1");
        check("img1_pulses",   32'(pulses),   32'(TOTAL));
        check("img1_checksum", 32'(checksum), 32'hE800);
        measure_hold("img1");
        check("img1_stream",   32'(stream_bad), 32'd0);

        // second image from DONE, random data, last byte on the falling edge
        check("done_core_reset", 32'(core_reset), 32'd0);
        stream_bad = 0;
        pulses = 0;
        step(1'b1, 1'b0, 0, 8'h00);
        check("reload_core_reset", 32'(core_reset), 32'd1);
        check("reload_checksum",   32'(checksum),   32'd0);
        check("reload_load_done",  32'(load_done),  32'd0);
        full_load(1'b0, 1'b1, "img2");
        check("img2_pulses",   32'(pulses),   32'(TOTAL));
        check("img2_checksum", 32'(checksum), 32'(m_chk));
        measure_hold("img2");
        check("img2_stream",   32'(stream_bad), 32'd0);

        // truncated image: one byte short of the program region
        stream_bad = 0;
        step(1'b1, 1'b0, 0, 8'h00);
        for (int a = 0; a < PROG - 1; a++) step(1'b1, 1'b1, a, 8'($urandom_range(0, 255)));
        step(1'b0, 1'b0, 0, 8'h00);
        check("short_load_err",   32'(load_err),   32'd1);
        check("short_load_done",  32'(load_done),  32'd0);
        check("short_core_reset", 32'(core_reset), 32'd1);
        check("short_stream",     32'(stream_bad), 32'd0);

        // reset in the middle of a download, download kept high afterwards
        stream_bad = 0;
        step(1'b1, 1'b0, 0, 8'h00);
        for (int a = 0; a < 100; a++) step(1'b1, 1'b1, a, 8'(a + 1));
        #2;
        reset = 1'b1;
        #1;
        check("abort_dn_wr",      32'(bus.dn_wr),   32'd0);
        check("abort_dn_addr",    32'(bus.dn_addr), 32'd0);
        check("abort_dn_data",    32'(bus.dn_data), 32'd0);
        check("abort_rom_sel",    32'(bus.rom_sel), 32'd0);
        check("abort_checksum",   32'(checksum),    32'd0);
        check("abort_load_err",   32'(load_err),    32'd0);
        check("abort_core_reset", 32'(core_reset),  32'd1);
        model_reset();
        @(posedge clk_25);
        #1;
        reset = 1'b0;
        pulses = 0;
        for (int a = 0; a < 20; a++) step(1'b1, 1'b1, 100 + a, 8'(a));
        for (int a = 0; a < 5; a++) step(1'b1, 1'b1, a, 8'(a));
        check("abort_no_pulses", 32'(pulses),     32'd0);
        check("abort_stream",    32'(stream_bad), 32'd0);

        // randomized partial downloads with occasional bad addresses
        stream_bad = 0;
        for (int it = 0; it < 20; it++) begin
            int len;
            int addr;
            for (int k = 0; k < 3; k++)
                step(1'b0, 1'($urandom_range(0, 1)), $urandom_range(0, 40), 8'($urandom_range(0, 255)));
            step(1'b1, 1'b0, 0, 8'h00);
            len = $urandom_range(1, 60);
            for (int k = 0; k < len; k++) begin
                case ($urandom_range(0, 19))
                    0:       addr = $urandom_range(0, 80);
                    1:       addr = TOTAL + $urandom_range(0, 5);
                    default: addr = m_count;
                endcase
                step(1'b1, 1'($urandom_range(0, 4) != 0), addr, 8'($urandom_range(0, 255)));
            end
            step(1'b0, 1'($urandom_range(0, 1)), m_count, 8'($urandom_range(0, 255)));
        end
        check("rand_load_err", 32'(load_err),   32'd1);
        check("rand_stream",   32'(stream_bad), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
